// File: rtl/bch_pkg.sv
// Shared definitions for the BCH decoder slice.
//   state_e     : phase sequencer state encodings (also exported as the debug phase)
//   code_cfg_t  : per-code (n-1, m, t) configuration tuple
//   code_lookup : code select -> configuration tuple (code 0 aliases code 3)
//   prim_poly   : primitive polynomial of GF(2^m) for each supported field degree
package bch_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SYN  = 3'd2,
    S_BER  = 3'd3,
    S_CHI  = 3'd4,
    S_OUT  = 3'd5
  } state_e;

  typedef struct packed {
    logic [9:0] n;  // codeword length minus 1
    logic [3:0] m;  // field degree
    logic [2:0] t;  // correction capability
  } code_cfg_t;

  localparam code_cfg_t CFG_63   = '{n: 10'd63,   m: 4'd6,  t: 3'd2};
  localparam code_cfg_t CFG_255  = '{n: 10'd255,  m: 4'd8,  t: 3'd2};
  localparam code_cfg_t CFG_1023 = '{n: 10'd1023, m: 4'd10, t: 3'd4};

  localparam logic [10:0] PRIM_M6  = 11'h043;
  localparam logic [10:0] PRIM_M8  = 11'h11D;
  localparam logic [10:0] PRIM_M10 = 11'h409;

  function automatic code_cfg_t code_lookup(input logic [1:0] code);
    code_cfg_t c;
    case (code)
      2'd1:    c = CFG_63;
      2'd2:    c = CFG_255;
      default: c = CFG_1023;
    endcase
    return c;
  endfunction

  function automatic logic [10:0] prim_poly(input logic [3:0] m);
    logic [10:0] p;
    case (m)
      4'd6:    p = PRIM_M6;
      4'd8:    p = PRIM_M8;
      default: p = PRIM_M10;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bch_cfg_decode.sv
// Combinational code-select decoder, shared by the sequencer and the datapath units.
// Ports:
//   code_i     : code select (1=(63,51), 2=(255,239), 3/0=(1023,983))
//   n_o        : codeword length minus 1
//   m_o        : field degree
//   t_o        : correction capability
//   beats_m1_o : number of 8-symbol load beats minus 1
module bch_cfg_decode
  import bch_pkg::*;
#(
  parameter int BEAT_W = 7
) (
  input  logic [1:0]        code_i,
  output logic [9:0]        n_o,
  output logic [3:0]        m_o,
  output logic [2:0]        t_o,
  output logic [BEAT_W-1:0] beats_m1_o
);

  code_cfg_t cfg;

  always_comb begin
    cfg        = code_lookup(code_i);
    n_o        = cfg.n;
    m_o        = cfg.m;
    t_o        = cfg.t;
    // n is 2^m - 1, so (n+1)/8 - 1 is simply n with its low three bits dropped
    beats_m1_o = BEAT_W'(cfg.n >> 3);
  end

endmodule

// File: rtl/bch_phase_ctrl.sv
// BCH decoder phase sequencer: IDLE -> LOAD -> SYN -> BER -> CHI -> OUT -> IDLE.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   set, mode, code            : codeword request (sampled in IDLE only)
//   ready, load_we, load_addr  : load handshake; load_addr counts beats down to 0
//   cfg_n/m/t/mode             : latched configuration shared with all units
//   *_start / *_done           : one-cycle start/done pulses per datapath unit
//   syn_zero, ber_fail         : qualifiers valid with syn_done / ber_done
//   busy, uncorr, phase        : status (uncorr sticky until next accepted set)
module bch_phase_ctrl
  import bch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2048,
  parameter int BEAT_W      = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set,
  input  logic              mode,
  input  logic [1:0]        code,
  output logic              ready,
  output logic              load_we,
  output logic [BEAT_W-1:0] load_addr,
  output logic [9:0]        cfg_n,
  output logic [3:0]        cfg_m,
  output logic [2:0]        cfg_t,
  output logic              cfg_mode,
  output logic              syn_start,
  input  logic              syn_done,
  input  logic              syn_zero,
  output logic              ber_start,
  input  logic              ber_done,
  input  logic              ber_fail,
  output logic              chi_start,
  input  logic              chi_done,
  output logic              out_start,
  input  logic              out_done,
  output logic              busy,
  output logic              uncorr,
  output logic [2:0]        phase
);

  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              state_q;
  logic                ready_q;
  logic [BEAT_W-1:0]   addr_q;
  logic [9:0]          n_q;
  logic [3:0]          m_q;
  logic [2:0]          t_q;
  logic                mode_q;
  logic                syn_start_q, ber_start_q, chi_start_q, out_start_q;
  logic                busy_q;
  logic                uncorr_q;
  logic [WAIT_W-1:0]   wait_q;

  logic [9:0]          dec_n;
  logic [3:0]          dec_m;
  logic [2:0]          dec_t;
  logic [BEAT_W-1:0]   dec_beats_m1;
  logic                timeout;

  bch_cfg_decode #(.BEAT_W(BEAT_W)) u_cfg_decode (
    .code_i     (code),
    .n_o        (dec_n),
    .m_o        (dec_m),
    .t_o        (dec_t),
    .beats_m1_o (dec_beats_m1)
  );

  // Last waiting cycle of the current state; a done in this cycle still wins.
  assign timeout = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      n_q         <= 10'd1023;
      m_q         <= 4'd10;
      t_q         <= 3'd4;
      mode_q      <= 1'b0;
      syn_start_q <= 1'b0;
      ber_start_q <= 1'b0;
      chi_start_q <= 1'b0;
      out_start_q <= 1'b0;
      busy_q      <= 1'b0;
      uncorr_q    <= 1'b0;
      wait_q      <= '0;
    end else begin
      syn_start_q <= 1'b0;
      ber_start_q <= 1'b0;
      chi_start_q <= 1'b0;
      out_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (set) begin
            n_q      <= dec_n;
            m_q      <= dec_m;
            t_q      <= dec_t;
            mode_q   <= mode;
            uncorr_q <= 1'b0;
            addr_q   <= dec_beats_m1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (addr_q == '0) begin
            ready_q     <= 1'b0;
            syn_start_q <= 1'b1;
            wait_q      <= '0;
            state_q     <= S_SYN;
          end else begin
            addr_q <= addr_q - 1'b1;
          end
        end
        S_SYN: begin
          if (syn_done) begin
            wait_q <= '0;
            if (syn_zero) begin
              out_start_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              ber_start_q <= 1'b1;
              state_q     <= S_BER;
            end
          end else if (timeout) begin
            wait_q      <= '0;
            uncorr_q    <= 1'b1;
            out_start_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_BER: begin
          if (ber_done) begin
            wait_q <= '0;
            if (ber_fail) begin
              uncorr_q    <= 1'b1;
              out_start_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              chi_start_q <= 1'b1;
              state_q     <= S_CHI;
            end
          end else if (timeout) begin
            wait_q      <= '0;
            uncorr_q    <= 1'b1;
            out_start_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_CHI: begin
          if (chi_done || timeout) begin
            wait_q      <= '0;
            uncorr_q    <= uncorr_q | ~chi_done;
            out_start_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_done || timeout) begin
            wait_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          wait_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign load_we   = ready_q;
  assign load_addr = addr_q;
  assign cfg_n     = n_q;
  assign cfg_m     = m_q;
  assign cfg_t     = t_q;
  assign cfg_mode  = mode_q;
  assign syn_start = syn_start_q;
  assign ber_start = ber_start_q;
  assign chi_start = chi_start_q;
  assign out_start = out_start_q;
  assign busy      = busy_q;
  assign uncorr    = uncorr_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_bch_phase_ctrl.sv
// Self-checking bench for bch_phase_ctrl. Each transaction is planned up front as
// a per-cycle schedule (inputs to drive, outputs expected) computed from phase
// durations; a driver replays the inputs and one compare process checks outputs.
module tb_bch_phase_ctrl;

  localparam int TO   = 2048;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       set = 1'b0, mode = 1'b0;
  logic [1:0] code = 2'd0;
  logic       syn_done = 1'b0, syn_zero = 1'b0, ber_done = 1'b0, ber_fail = 1'b0;
  logic       chi_done = 1'b0, out_done = 1'b0;
  logic       ready, load_we, cfg_mode, syn_start, ber_start, chi_start, out_start;
  logic       busy, uncorr;
  logic [6:0] load_addr;
  logic [9:0] cfg_n;
  logic [3:0] cfg_m;
  logic [2:0] cfg_t, phase;

  always #5 clk = ~clk;

  bch_phase_ctrl #(.TIMEOUT_CYC(TO), .BEAT_W(7)) dut (
    .clk(clk), .rstn(rstn), .set(set), .mode(mode), .code(code),
    .ready(ready), .load_we(load_we), .load_addr(load_addr),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_t(cfg_t), .cfg_mode(cfg_mode),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .ber_start(ber_start), .ber_done(ber_done), .ber_fail(ber_fail),
    .chi_start(chi_start), .chi_done(chi_done),
    .out_start(out_start), .out_done(out_done),
    .busy(busy), .uncorr(uncorr), .phase(phase)
  );

  // Expected outputs per cycle
  int       e_phase[MAXC];
  bit       e_ready[MAXC];
  int       e_addr [MAXC];
  bit [3:0] e_start[MAXC];  // {out, chi, ber, syn}
  bit       e_unc  [MAXC];
  int       e_n[MAXC], e_m[MAXC], e_t[MAXC];
  bit       e_mode [MAXC];
  // Inputs to drive per cycle
  bit       d_set [MAXC];
  bit       d_mode[MAXC];
  bit [1:0] d_code[MAXC];
  bit [3:0] d_done[MAXC];   // {out, chi, ber, syn}
  bit [3:0] d_flag[MAXC];   // bit0 syn_zero, bit1 ber_fail
  bit       d_rst [MAXC];

  int p = 0;
  int m_n = 1023, m_m = 10, m_t = 4;
  bit m_mode = 1'b0, m_unc = 1'b0;
  int last_load = 0;

  int checks = 0, failures = 0;
  int cur = -1;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cur, act, exp);
    end
  endtask

  // One planned cycle. Done pulses of units not owning this phase are random
  // noise, as are the qualifier flags; the DUT must ignore all of it.
  task automatic fill(input int ph, input bit rdy, input int addr, input bit [3:0] st);
    if (p >= MAXC) begin
      $display("FAIL plan_overflow cyc=%0d got=%0d exp<%0d", cur, p, MAXC);
      $fatal(1);
    end
    e_phase[p] = ph; e_ready[p] = rdy; e_addr[p] = addr; e_start[p] = st;
    e_unc[p] = m_unc; e_n[p] = m_n; e_m[p] = m_m; e_t[p] = m_t; e_mode[p] = m_mode;
    for (int u = 0; u < 4; u++)
      d_done[p][u] = (ph != u + 2) && ($urandom_range(7) == 0);
    d_flag[p] = 4'($urandom);
    p++;
  endtask

  task automatic idle(input int k);
    repeat (k) fill(0, 1'b0, 0, 4'd0);
  endtask

  // A wait phase with its done d cycles after the start (d<0 or d>=TO: withheld).
  task automatic wait_unit(input int ph, input int unit, input int d, input bit flag,
                           output bit to);
    int s;
    int n;
    s = p;
    n = (d >= 0 && d < TO) ? d + 1 : TO;
    for (int i = 0; i < n; i++) fill(ph, 1'b0, 0, (i == 0) ? 4'(1 << unit) : 4'd0);
    if (d >= 0 && d < TO) begin
      d_done[s + d][unit] = 1'b1;
      d_flag[s + d][unit] = flag;
      to = 1'b0;
    end else begin
      to = 1'b1;
    end
  endtask

  task automatic txn(input int code_v, input bit mode_v, input int dsyn, input bit zero,
                     input int dber, input bit fail, input int dchi, input int dout,
                     input bit stray);
    int b;
    int cs;
    bit to;
    d_set[p] = 1'b1; d_code[p] = 2'(code_v); d_mode[p] = mode_v;
    fill(0, 1'b0, 0, 4'd0);
    case (code_v)
      1:       begin m_n = 63;   m_m = 6;  m_t = 2; end
      2:       begin m_n = 255;  m_m = 8;  m_t = 2; end
      default: begin m_n = 1023; m_m = 10; m_t = 4; end
    endcase
    m_mode = mode_v;
    m_unc  = 1'b0;
    b = (m_n + 1) / 8;
    last_load = p;
    for (int i = 0; i < b; i++) fill(1, 1'b1, b - 1 - i, 4'd0);
    if (stray) begin
      d_set[last_load + 2] = 1'b1; d_code[last_load + 2] = 2'd1; d_mode[last_load + 2] = ~mode_v;
    end
    wait_unit(2, 0, dsyn, zero, to);
    if (to) m_unc = 1'b1;
    else if (!zero) begin
      wait_unit(3, 1, dber, fail, to);
      if (to || fail) m_unc = 1'b1;
      else begin
        cs = p;
        wait_unit(4, 2, dchi, 1'b0, to);
        if (stray) begin
          d_set[cs + 1] = 1'b1; d_code[cs + 1] = 2'd2; d_mode[cs + 1] = ~mode_v;
        end
        if (to) m_unc = 1'b1;
      end
    end
    wait_unit(5, 3, dout, 1'b0, to);
  endtask

  // Replace the plan from cycle r on with a reset pulse followed by IDLE.
  task automatic abort_at(input int r);
    for (int c = r; c < p; c++) begin d_set[c] = 1'b0; d_done[c] = '0; end
    p = r;
    m_n = 1023; m_m = 10; m_t = 4; m_mode = 1'b0; m_unc = 1'b0;
    d_rst[r] = 1'b1;
    fill(0, 1'b0, 0, 4'd0);
  endtask

  // Compare process
  always @(negedge clk) begin
    if (run) begin
      chk("phase",     32'(phase),     32'(e_phase[cur]));
      chk("ready",     32'(ready),     32'(e_ready[cur]));
      chk("load_we",   32'(load_we),   32'(e_ready[cur]));
      chk("load_addr", 32'(load_addr), 32'(e_addr[cur]));
      chk("starts",    32'({out_start, chi_start, ber_start, syn_start}), 32'(e_start[cur]));
      chk("busy",      32'(busy),      32'(e_phase[cur] != 0));
      chk("uncorr",    32'(uncorr),    32'(e_unc[cur]));
      chk("cfg_n",     32'(cfg_n),     32'(e_n[cur]));
      chk("cfg_m",     32'(cfg_m),     32'(e_m[cur]));
      chk("cfg_t",     32'(cfg_t),     32'(e_t[cur]));
      chk("cfg_mode",  32'(cfg_mode),  32'(e_mode[cur]));
    end
  end

  initial begin
    int cnt;
    int ofirst;
    // ---------------- plan ----------------
    idle(3);
    // code 1, hard decision: 8 beats, addr 7..0, syn_start right after
    txn(1, 1'b0, 3, 1'b0, 4, 1'b0, 2, 3, 1'b0);
    cnt = 0;
    for (int c = last_load; c < last_load + 20; c++) if (e_ready[c]) cnt++;
    chk("pin_beats_63", 32'(cnt), 32'd8);
    chk("pin_addr_first", 32'(e_addr[last_load]), 32'd7);
    chk("pin_addr_last", 32'(e_addr[last_load + 7]), 32'd0);
    chk("pin_cfg_63", 32'({e_n[last_load], e_m[last_load], e_t[last_load]}),
        32'({32'd63, 32'd6, 32'd2}));
    chk("pin_synstart", 32'(e_start[last_load + 8]), 32'd1);
    idle(2);
    // code 3 full flow, every done 5 cycles after its start
    txn(3, 1'b1, 5, 1'b0, 5, 1'b0, 5, 5, 1'b0);
    idle(1);
    // code 2, syndromes zero: straight to OUT
    txn(2, 1'b0, 4, 1'b1, 0, 1'b0, 0, 2, 1'b0);
    // code 3, locator failure: uncorr, Chien skipped
    txn(3, 1'b0, 2, 1'b0, 6, 1'b1, 0, 1, 1'b0);
    idle(2);
    // code 0 aliases code 3; stray set during LOAD and CHI; clears uncorr
    txn(0, 1'b1, 1, 1'b0, 1, 1'b0, 3, 1, 1'b1);
    chk("pin_beats_1023", 32'(e_addr[last_load]), 32'd127);
    // withheld ber_done: timeout after 2048 cycles in BER
    txn(1, 1'b0, 2, 1'b0, -1, 1'b0, 0, 2, 1'b0);
    cnt = 0; ofirst = -1;
    for (int c = last_load; c < p; c++) begin
      if (e_phase[c] == 3) cnt++;
      if (e_phase[c] == 5 && ofirst < 0) ofirst = c;
    end
    chk("pin_ber_timeout_len", 32'(cnt), 32'd2048);
    chk("pin_timeout_out", 32'({e_unc[ofirst], e_start[ofirst]}), 32'h18);
    // ber_done on the timeout cycle itself: done wins, goes to CHI
    txn(1, 1'b1, 2, 1'b0, TO - 1, 1'b0, 1, 1, 1'b0);
    // withheld out_done: OUT times out back to IDLE
    txn(2, 1'b0, 1, 1'b0, 1, 1'b0, 1, -1, 1'b0);
    idle(2);
    for (int k = 0; k < 10; k++) begin
      txn($urandom_range(3), 1'($urandom_range(1)), $urandom_range(8),
          $urandom_range(3) == 0, $urandom_range(8), $urandom_range(3) == 0,
          $urandom_range(8), $urandom_range(8), 1'($urandom_range(1)));
      idle($urandom_range(2));
    end
    // reset in the middle of LOAD
    txn(3, 1'b1, 5, 1'b0, 5, 1'b0, 5, 5, 1'b0);
    abort_at(last_load + 10);
    idle(20);
    txn(1, 1'b0, 1, 1'b0, 1, 1'b0, 1, 1, 1'b0);
    idle(3);

    // ---------------- run ----------------
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < p; c++) begin
      @(posedge clk);
      #1;
      rstn     = !d_rst[c];
      set      = d_set[c];
      mode     = d_mode[c];
      code     = d_code[c];
      syn_done = d_done[c][0];
      syn_zero = d_flag[c][0];
      ber_done = d_done[c][1];
      ber_fail = d_flag[c][1];
      chi_done = d_done[c][2];
      out_done = d_done[c][3];
      cur      = c;
      run      = 1'b1;
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
